// File: rtl/lfsr_random_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_random_pkg
//  Description : Shared definitions for the Drums Hero pseudo-random note
//                generator: maximal-length tap masks for LFSR widths 4..16,
//                the generator FSM state type, the default seed and a
//                tap-mask lookup helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_random_pkg;

    // Generator FSM. RESTEP is only reachable when the no-repeat feature is
    // compiled into lfsr_random_gen.
    typedef enum logic [0:0] {
        COUNT  = 1'b0,
        RESTEP = 1'b1
    } lfsr_state_t;

    // Reset / lock-up recovery value, truncated to the LFSR width at use.
    localparam logic [15:0] c_DEFAULT_SEED = 16'hACE1;

    // Fibonacci tap masks, bit k set means state bit k feeds the XOR.
    // Polynomial x^n + ... maps term x^m onto state bit m-1.
    localparam logic [16:4][15:0] c_TAP_TABLE = {
        16'hD008,   // 16: x^16 + x^15 + x^13 + x^4 + 1
        16'h6000,   // 15: x^15 + x^14 + 1
        16'h2015,   // 14: x^14 + x^5  + x^3  + x^1 + 1
        16'h100D,   // 13: x^13 + x^4  + x^3  + x^1 + 1
        16'h0829,   // 12: x^12 + x^6  + x^4  + x^1 + 1
        16'h0500,   // 11: x^11 + x^9  + 1
        16'h0240,   // 10: x^10 + x^7  + 1
        16'h0110,   //  9: x^9  + x^5  + 1
        16'h00B8,   //  8: x^8  + x^6  + x^5  + x^4 + 1
        16'h0060,   //  7: x^7  + x^6  + 1
        16'h0030,   //  6: x^6  + x^5  + 1
        16'h0014,   //  5: x^5  + x^3  + 1
        16'h000C    //  4: x^4  + x^3  + 1
    };

    // Tap mask for a given width; unsupported widths return an empty mask.
    function automatic logic [15:0] tap_mask(input int width);
        logic [4:0] idx;
        idx = 5'(width);
        if (width < 4 || width > 16) begin
            return 16'h0000;
        end
        return c_TAP_TABLE[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_random_gen_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_core
//  Description : Shift-left Fibonacci LFSR state register with feedback XOR,
//                seed loading (zero seed replaced by SEED) and a lock-up
//                guard that returns an all-zero state to SEED on the next
//                step. Priority: rst > load > step.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_random_pkg::*;
#(
    parameter int          LFSR_W = 16,
    parameter logic [15:0] SEED   = c_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next
);

    localparam logic [15:0]       c_TAPS_FULL = tap_mask(LFSR_W);
    localparam logic [LFSR_W-1:0] c_TAPS      = c_TAPS_FULL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] c_SEED      = SEED[LFSR_W-1:0];

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;
    logic [LFSR_W-1:0] w_load_val;
    logic              w_fb;

    // Feedback and next-state; an all-zero state would never leave zero, so
    // the step value is forced to the seed instead.
    always_comb begin
        w_fb       = ^(r_state & c_TAPS);
        w_next     = {r_state[LFSR_W-2:0], w_fb};
        w_load_val = load_val;
        if (r_state == '0) begin
            w_next = c_SEED;
        end
        if (load_val == '0) begin
            w_load_val = c_SEED;
        end
    end

    // State register: reset, then seed load, then a normal step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_SEED;
        end else if (load) begin
            r_state <= w_load_val;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state = r_state;
    assign next  = w_next;

endmodule
`default_nettype wire

// File: rtl/lfsr_random_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_random_gen
//  Description : Parametrised pseudo-random drum-lane pattern generator.
//                A rate divider steps an LFSR every `period` enabled ticks
//                (0 treated as 1) and publishes the low OUT_W bits of the
//                new state with a one-cycle out_valid strobe.
//                Optional build macro LFSR_RANDOM_GEN_NO_REPEAT_EN: when
//                defined, a published value never equals the previous one;
//                the LFSR keeps stepping in state RESTEP until it differs.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_random_gen
    import lfsr_random_pkg::*;
#(
    parameter int          LFSR_W = 16,
    parameter int          OUT_W  = 4,
    parameter logic [15:0] SEED   = c_DEFAULT_SEED,
    parameter int          DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [DIV_W-1:0]  period,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid
);

    localparam logic [DIV_W-1:0] c_COUNT_ONE = DIV_W'(1);

    lfsr_state_t       r_fsm;
    lfsr_state_t       w_fsm_nxt;
    logic [DIV_W-1:0]  r_count;
    logic [DIV_W-1:0]  w_count_nxt;
    logic [OUT_W-1:0]  r_out;
    logic              r_out_valid;

    logic [DIV_W-1:0]  w_eff_period;
    logic              w_terminal;
    logic              w_dup;
    logic              w_step;
    logic              w_publish;
    logic [LFSR_W-1:0] w_state;
    logic [LFSR_W-1:0] w_next;
    logic              w_unused;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (w_step),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (w_state),
        .next     (w_next)
    );

    // Terminal count; comparing with >= means a period lowered below the
    // current count fires on the next enabled cycle instead of wrapping.
    always_comb begin
        w_eff_period = (period == '0) ? c_COUNT_ONE : period;
        w_terminal   = (r_count >= (w_eff_period - c_COUNT_ONE));
    end

`ifdef LFSR_RANDOM_GEN_NO_REPEAT_EN
    assign w_dup = (w_next[OUT_W-1:0] == r_out);
`else
    assign w_dup = 1'b0;
`endif

    // Next-state, divider and step/publish decisions; seed_load overrides
    // any step and returns the FSM to COUNT even while disabled.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_count_nxt = r_count;
        w_step      = 1'b0;
        w_publish   = 1'b0;
        if (seed_load) begin
            w_fsm_nxt   = COUNT;
            w_count_nxt = '0;
        end else if (enable) begin
            case (r_fsm)
                COUNT: begin
                    if (w_terminal) begin
                        w_step      = 1'b1;
                        w_count_nxt = '0;
                        if (w_dup) begin
                            w_fsm_nxt = RESTEP;
                        end else begin
                            w_publish = 1'b1;
                        end
                    end else begin
                        w_count_nxt = r_count + c_COUNT_ONE;
                    end
                end
                RESTEP: begin
                    w_step      = 1'b1;
                    w_count_nxt = '0;
                    if (!w_dup) begin
                        w_publish = 1'b1;
                        w_fsm_nxt = COUNT;
                    end
                end
                default: begin
                    w_fsm_nxt = COUNT;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= COUNT;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Divider count and published output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= w_publish;
            if (w_publish) begin
                r_out <= w_next[OUT_W-1:0];
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

    // Upper LFSR bits and the raw state are intentionally not published.
    assign w_unused = ^{w_state, w_next};

endmodule
`default_nettype wire

// File: tb/tb_lfsr_random_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_random_gen
//  Description : Directed self-checking bench for lfsr_random_gen using three
//                instances: 4/4-bit (sequence, zero handling, freeze,
//                seed priority, reset), 16/4-bit (rate divider) and 8/2-bit
//                (consecutive-duplicate behaviour over 1000 outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lfsr_random_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: LFSR_W=4, OUT_W=4
    logic        rst_a, en_a, ld_a, vld_a;
    logic [3:0]  seed_a, out_a;
    logic [23:0] per_a;
    // Instance B: LFSR_W=16, OUT_W=4
    logic        rst_b, en_b, ld_b, vld_b;
    logic [15:0] seed_b;
    logic [3:0]  out_b;
    logic [23:0] per_b;
    // Instance C: LFSR_W=8, OUT_W=2
    logic        rst_c, en_c, ld_c, vld_c;
    logic [7:0]  seed_c;
    logic [1:0]  out_c;
    logic [23:0] per_c;

    lfsr_random_gen #(.LFSR_W(4), .OUT_W(4), .SEED(16'hACE1), .DIV_W(24)) u_dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .seed_load(ld_a), .seed_in(seed_a),
        .period(per_a), .out(out_a), .out_valid(vld_a));

    lfsr_random_gen #(.LFSR_W(16), .OUT_W(4), .SEED(16'hACE1), .DIV_W(24)) u_dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .seed_load(ld_b), .seed_in(seed_b),
        .period(per_b), .out(out_b), .out_valid(vld_b));

    lfsr_random_gen #(.LFSR_W(8), .OUT_W(2), .SEED(16'hACE1), .DIV_W(24)) u_dut_c (
        .clk(clk), .rst(rst_c), .enable(en_c), .seed_load(ld_c), .seed_in(seed_c),
        .period(per_c), .out(out_c), .out_valid(vld_c));

    // Hand-derived x^4+x^3+1 sequence starting from state 1.
    logic [3:0] seq_a [0:14] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    // Independent reference steps: x^16+x^15+x^13+x^4+1 and x^8+x^6+x^5+x^4+1.
    function automatic logic [15:0] step16(input logic [15:0] s);
        if (s == 16'h0) return 16'hACE1;
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] s);
        if (s == 8'h0) return 8'hE1;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m16;
        logic [7:0]  m8;
        logic [1:0]  m_prev, prev_c;
        int          quiet, n_out, mism, dups, cyc;
        bit          nr_mode;

        rst_a = 1'b1; en_a = 1'b0; ld_a = 1'b0; seed_a = '0; per_a = 24'd1;
        rst_b = 1'b1; en_b = 1'b0; ld_b = 1'b0; seed_b = '0; per_b = 24'd1;
        rst_c = 1'b1; en_c = 1'b0; ld_c = 1'b0; seed_c = '0; per_c = 24'd1;
        repeat (2) tick();
        check("rst_out_a", out_a, 0);
        check("rst_vld_a", vld_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_vld_b", vld_b, 0);
        check("rst_out_c", out_c, 0);
        check("rst_vld_c", vld_c, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Base sequence: load seed 1, then one output per cycle; later
        // period=0 must continue exactly as period=1.
        ld_a = 1'b1; seed_a = 4'h1;
        tick();
        check("load_vld", vld_a, 0);
        check("load_out", out_a, 0);
        ld_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 45; i++) begin
            per_a = (i >= 30) ? 24'd0 : 24'd1;
            tick();
            check((i >= 30) ? "seq_p0" : "seq_p1", out_a, seq_a[i % 15]);
            check("seq_vld", vld_a, 1);
        end

        // Freeze: no strobe and output held for 20 cycles.
        en_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("frz_vld", vld_a, 0);
            check("frz_out", out_a, 4'h1);
        end
        en_a = 1'b1;
        tick();
        check("unfrz_out", out_a, 4'h2);
        check("unfrz_vld", vld_a, 1);

        // seed_load on a terminal cycle wins: no strobe, out held.
        ld_a = 1'b1; seed_a = 4'h9;
        tick();
        check("ldterm_vld", vld_a, 0);
        check("ldterm_out", out_a, 4'h2);
        ld_a = 1'b0;
        tick();
        check("after_ld_out", out_a, 4'h3);
        check("after_ld_vld", vld_a, 1);

        // Zero seed is replaced by SEED (low nibble 1).
        ld_a = 1'b1; seed_a = 4'h0;
        tick();
        check("zseed_vld", vld_a, 0);
        ld_a = 1'b0;
        tick();
        check("zseed_out0", out_a, 4'h2);
        tick();
        check("zseed_out1", out_a, 4'h4);

        // Reset mid-run, then first output is the step from SEED.
        rst_a = 1'b1;
        tick();
        check("mrst_out", out_a, 0);
        check("mrst_vld", vld_a, 0);
        rst_a = 1'b0;
        tick();
        check("mrst_first", out_a, 4'h2);
        check("mrst_fvld", vld_a, 1);

        // Rate divider on the 16-bit instance.
        m16 = 16'hACE1;
        en_b = 1'b1; per_b = 24'd3;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("div3_vld", vld_b, 32'((k % 3) == 2));
            if ((k % 3) == 2) begin
                m16 = step16(m16);
                check("div3_out", out_b, m16[3:0]);
            end
        end
        per_b = 24'd100;
        quiet = 0;
        repeat (50) begin
            tick();
            quiet += int'(vld_b);
        end
        check("p100_quiet", quiet, 0);
        per_b = 24'd5;
        tick();
        check("plower_vld", vld_b, 1);
        m16 = step16(m16);
        check("plower_out", out_b, m16[3:0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("div5_vld", vld_b, 32'(k == 4));
        end

        // Consecutive-duplicate behaviour over 1000 published outputs.
`ifdef LFSR_RANDOM_GEN_NO_REPEAT_EN
        nr_mode = 1'b1;
`else
        nr_mode = 1'b0;
`endif
        m8 = 8'hE1; m_prev = 2'b00; prev_c = 2'b00;
        n_out = 0; mism = 0; dups = 0; cyc = 0;
        en_c = 1'b1; per_c = 24'd1;
        while (n_out < 1000 && cyc < 4000) begin
            tick();
            cyc++;
            if (vld_c) begin
                do begin
                    m8 = step8(m8);
                end while (nr_mode && (m8[1:0] == m_prev));
                m_prev = m8[1:0];
                if (out_c != m8[1:0]) mism++;
                if (n_out > 0 && out_c == prev_c) dups++;
                prev_c = out_c;
                n_out++;
            end
        end
        check("nr_count", n_out, 1000);
        check("nr_seq_mism", mism, 0);
`ifdef LFSR_RANDOM_GEN_NO_REPEAT_EN
        check("nr_dups", dups, 0);
`else
        check("dup_seen", 32'(dups > 0), 1);
        check("dup_cycles", cyc, 1000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
